// File: rtl/light_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : light_pattern_player
// Purpose  : Avalon-MM master that plays an LED pattern table out of a
//            128x32 single-port on-chip RAM (1-cycle read latency). Each
//            entry carries a hold count in [31:18] and a pattern in [17:0];
//            a zero hold count is an end marker (finish or loop).
// Revision : 1.0 - initial release
// ============================================================================
module light_pattern_player #(
    parameter int ADDR_WIDTH = 7,
    parameter int LED_WIDTH  = 18,
    parameter int HOLD_WIDTH = 14,
    parameter int PRESCALE   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [31:0]           m_writedata,
    output logic [3:0]            m_byteenable,
    output logic                  m_clken,
    input  logic [31:0]           m_readdata,
    output logic [LED_WIDTH-1:0]  leds,
    output logic                  busy,
    output logic                  entry_done,
    output logic                  wrapped
);

    // Tick counter only needs to reach PRESCALE-1 (PRESCALE >= 2).
    localparam int                  c_TICK_W    = $clog2(PRESCALE);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(PRESCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [c_TICK_W-1:0]    r_tick_cnt;
    logic [HOLD_WIDTH-1:0]  r_hold_cnt;
    logic [LED_WIDTH-1:0]   r_leds;
    logic                   r_entry_done;
    logic                   r_wrapped;

    logic [HOLD_WIDTH-1:0]  w_rd_hold;
    logic [LED_WIDTH-1:0]   w_rd_pattern;
    logic                   w_rd_is_marker;
    logic                   w_tick_last;
    logic                   w_hold_expire;

    // Field split of the word returned by the RAM during LATCH.
    assign w_rd_hold      = m_readdata[LED_WIDTH +: HOLD_WIDTH];
    assign w_rd_pattern   = m_readdata[LED_WIDTH-1:0];
    assign w_rd_is_marker = (w_rd_hold == '0);

    // The last tick of the last hold unit closes the entry.
    assign w_tick_last    = (r_tick_cnt == c_TICK_LAST);
    assign w_hold_expire  = (r_state == ST_HOLD) && w_tick_last &&
                            (r_hold_cnt == HOLD_WIDTH'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; stop overrides every transition (and drops a
    // coincident start because IDLE simply stays IDLE).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_LATCH;
            end
            ST_LATCH: begin
                if (!w_rd_is_marker) begin
                    w_next_state = ST_HOLD;
                end else if (loop_en) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_hold_expire) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (stop) begin
            w_next_state = ST_IDLE;
        end
    end

    // Datapath: pointer, counters, LED register and status flags. Nothing
    // here moves on a stop cycle so leds and ptr are retained and
    // entry_done cannot fire on an aborted hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_tick_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_leds       <= '0;
            r_entry_done <= 1'b0;
            r_wrapped    <= 1'b0;
        end else begin
            r_entry_done <= 1'b0;
            if (!stop) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_ptr     <= start_addr;
                            r_wrapped <= 1'b0;
                        end
                    end
                    ST_LATCH: begin
                        if (!w_rd_is_marker) begin
                            r_leds     <= w_rd_pattern;
                            r_hold_cnt <= w_rd_hold;
                            r_tick_cnt <= '0;
                        end else if (loop_en) begin
                            r_ptr <= start_addr;
                        end
                    end
                    ST_HOLD: begin
                        if (w_tick_last) begin
                            r_tick_cnt <= '0;
                            r_hold_cnt <= r_hold_cnt - HOLD_WIDTH'(1);
                            if (r_hold_cnt == HOLD_WIDTH'(1)) begin
                                r_entry_done <= 1'b1;
                                r_ptr        <= r_ptr + ADDR_WIDTH'(1);
                                if (r_ptr == c_PTR_LAST) begin
                                    r_wrapped <= 1'b1;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                    default: begin
                        // FETCH only presents the address.
                    end
                endcase
            end
        end
    end

    // Bus side: read-only master, address always follows the pointer.
    assign m_address    = r_ptr;
    assign m_chipselect = (r_state == ST_FETCH);
    assign m_write      = 1'b0;
    assign m_writedata  = 32'h0;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

    assign leds         = r_leds;
    assign busy         = (r_state != ST_IDLE);
    assign entry_done   = r_entry_done;
    assign wrapped      = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_light_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_pattern_player
// Purpose  : Directed self-checking bench for light_pattern_player with a
//            behavioural 1-cycle-latency pattern RAM and PRESCALE=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_light_pattern_player;

    localparam int AW = 7;
    localparam int LW = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_write;
    logic [31:0]   m_writedata;
    logic [3:0]    m_byteenable;
    logic          m_clken;
    logic [31:0]   m_readdata;
    logic [LW-1:0] leds;
    logic          busy;
    logic          entry_done;
    logic          wrapped;

    int total = 0;
    int bad = 0;
    int cs_cnt = 0;

    logic [31:0]   ram [128];
    logic [AW-1:0] r_ram_addr = '0;

    light_pattern_player #(
        .ADDR_WIDTH(7), .LED_WIDTH(18), .HOLD_WIDTH(14), .PRESCALE(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .start_addr(start_addr),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_clken(m_clken),
        .m_readdata(m_readdata), .leds(leds), .busy(busy),
        .entry_done(entry_done), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    // RAM slave: registered address, unregistered read data.
    always @(posedge clk) r_ram_addr <= m_address;
    assign m_readdata = ram[r_ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, and check the
    // constant bus outputs every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_chipselect === 1'b1) cs_cnt++;
        chk("m_write", {31'd0, m_write}, 32'd0);
        chk("be_clken", {27'd0, m_byteenable, m_clken}, 32'h1F);
        chk("m_writedata", m_writedata, 32'd0);
    endtask

    function automatic logic [31:0] ent(input int hold, input logic [17:0] pat);
        return {hold[13:0], pat};
    endfunction

    initial begin
        logic [LW-1:0] el;
        int p;
        for (int i = 0; i < 128; i++) ram[i] = 32'd0;
        ram[0] = ent(2, 18'h00055);
        ram[1] = ent(1, 18'h3FFFF);
        ram[2] = 32'd0;

        // ---- reset state ----
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_leds", {14'd0, leds}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, entry_done}, 32'd0);
        chk("rst_wrap", {31'd0, wrapped}, 32'd0);
        chk("rst_addr", {25'd0, m_address}, 32'd0);
        chk("rst_cs", {31'd0, m_chipselect}, 32'd0);

        // ---- scenario 1: play two entries then finish on end marker ----
        cs_cnt = 0;
        loop_en = 1'b0; start_addr = 7'd0; start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = 1'b0;
            el = (t < 3) ? 18'h0 : (t < 13) ? 18'h00055 : 18'h3FFFF;
            chk($sformatf("s1_leds_t%0d", t), {14'd0, leds}, {14'd0, el});
            chk($sformatf("s1_busy_t%0d", t), {31'd0, busy}, {31'd0, (t < 19)});
            chk($sformatf("s1_done_t%0d", t), {31'd0, entry_done}, {31'd0, (t == 11 || t == 17)});
            chk($sformatf("s1_cs_t%0d", t), {31'd0, m_chipselect}, {31'd0, (t == 1 || t == 11 || t == 17)});
            if (t == 1)  chk("s1_addr_t1", {25'd0, m_address}, 32'd0);
            if (t == 11) chk("s1_addr_t11", {25'd0, m_address}, 32'd1);
            if (t == 17) chk("s1_addr_t17", {25'd0, m_address}, 32'd2);
        end
        chk("s1_cs_count", cs_cnt, 32'd3);

        // ---- scenario 2: same table looping, period 18 ----
        cs_cnt = 0;
        loop_en = 1'b1; start = 1'b1;
        for (int t = 1; t <= 38; t++) begin
            tick();
            start = 1'b0;
            p = (t - 1) % 18;
            el = (t < 3) ? 18'h3FFFF : (p >= 2 && p <= 11) ? 18'h00055 : 18'h3FFFF;
            chk($sformatf("s2_leds_t%0d", t), {14'd0, leds}, {14'd0, el});
            chk($sformatf("s2_busy_t%0d", t), {31'd0, busy}, 32'd1);
            chk($sformatf("s2_done_t%0d", t), {31'd0, entry_done}, {31'd0, (p == 10 || p == 16)});
            chk($sformatf("s2_cs_t%0d", t), {31'd0, m_chipselect}, {31'd0, (p == 0 || p == 10 || p == 16)});
        end
        chk("s2_cs_count", cs_cnt, 32'd7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s2_stop_busy", {31'd0, busy}, 32'd0);
        chk("s2_stop_cs", {31'd0, m_chipselect}, 32'd0);
        loop_en = 1'b0;

        // ---- scenario 3: pointer rollover 127 -> 0 ----
        ram[127] = ent(1, 18'h00001);
        ram[0]   = 32'd0;
        start_addr = 7'd127; start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            start = 1'b0;
            chk($sformatf("s3_wrap_t%0d", t), {31'd0, wrapped}, {31'd0, (t >= 7)});
            chk($sformatf("s3_busy_t%0d", t), {31'd0, busy}, {31'd0, (t < 9)});
            if (t == 1) chk("s3_addr_t1", {25'd0, m_address}, 32'd127);
            if (t == 3) chk("s3_leds_t3", {14'd0, leds}, 32'd1);
            if (t == 7) chk("s3_done_t7", {31'd0, entry_done}, 32'd1);
        end
        chk("s3_addr_end", {25'd0, m_address}, 32'd0);
        chk("s3_leds_end", {14'd0, leds}, 32'd1);

        // ---- scenario 4: stop mid-HOLD, then start+stop together ----
        ram[0] = ent(2, 18'h00055);
        start_addr = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s4_wrap_cleared", {31'd0, wrapped}, 32'd0);
        repeat (4) tick();
        chk("s4_leds_hold", {14'd0, leds}, 32'h55);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s4_stop_busy", {31'd0, busy}, 32'd0);
        chk("s4_stop_leds", {14'd0, leds}, 32'h55);
        chk("s4_stop_done", {31'd0, entry_done}, 32'd0);
        chk("s4_stop_cs", {31'd0, m_chipselect}, 32'd0);
        for (int t = 0; t < 12; t++) begin
            tick();
            chk($sformatf("s4_nodone_%0d", t), {31'd0, entry_done | busy}, 32'd0);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("s4_both_busy", {31'd0, busy}, 32'd0);
        chk("s4_both_cs", {31'd0, m_chipselect}, 32'd0);
        tick();
        chk("s4_both_busy2", {31'd0, busy}, 32'd0);

        // ---- scenario 5: start ignored while busy, reset mid-HOLD ----
        ram[127] = ent(1, 18'h00001);
        start_addr = 7'd127; start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = (t == 10);
            if (t == 10) start_addr = 7'd5;
            if (t == 9)  chk("s5_leds_t9", {14'd0, leds}, 32'h55);
            if (t == 11) chk("s5_busy_t11", {31'd0, busy}, 32'd1);
            if (t == 11) chk("s5_wrap_t11", {31'd0, wrapped}, 32'd1);
            if (t == 17) chk("s5_done_t17", {31'd0, entry_done}, 32'd1);
            if (t == 17) chk("s5_addr_t17", {25'd0, m_address}, 32'd1);
            if (t == 19) chk("s5_leds_t19", {14'd0, leds}, 32'h3FFFF);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_rst_leds", {14'd0, leds}, 32'd0);
        chk("s5_rst_busy", {31'd0, busy}, 32'd0);
        chk("s5_rst_cs", {31'd0, m_chipselect}, 32'd0);
        chk("s5_rst_wrap", {31'd0, wrapped}, 32'd0);
        chk("s5_rst_addr", {25'd0, m_address}, 32'd0);
        tick();
        chk("s5_post_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_pattern_player.md
Name: light_pattern_player

Overview:
- Avalon-MM master that plays an LED pattern table stored in a 128x32 single-port on-chip RAM slave.
- The slave has a fixed 1-cycle read latency: address is registered inside the RAM and readdata is unregistered.
- The block fetches one entry at a time, drives the LED pattern, and holds it for a programmable number of prescaled ticks.
- It then advances, stops, or loops on an end marker. It sits between the pattern RAM (s2 port) and the board LED pins.

Parameters:
- ADDR_WIDTH, 7, RAM word address width (128 words).
- LED_WIDTH, 18, number of LED outputs; entry bits [LED_WIDTH-1:0].
- HOLD_WIDTH, 14, hold-count field, entry bits [31:18].
- PRESCALE, 50000, clk cycles per hold tick (1 ms at 50 MHz); legal range ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin playback at start_addr.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  on end marker: 1 = restart at start_addr, 0 = finish.
- start_addr  in  ADDR_WIDTH  first table entry; sampled on the accepted start.
- m_address  out  ADDR_WIDTH  RAM word address.
- m_chipselect  out  1  RAM select, asserted only in FETCH.
- m_write  out  1  constant 0.
- m_writedata  out  32  constant 0.
- m_byteenable  out  4  constant 4'hF.
- m_clken  out  1  constant 1.
- m_readdata  in  32  RAM read data, valid the cycle after FETCH.
- leds  out  LED_WIDTH  current pattern, registered.
- busy  out  1  high in any state other than IDLE.
- entry_done  out  1  one-cycle pulse when an entry's hold expires.
- wrapped  out  1  sticky; set when the pointer rolls over from 2^ADDR_WIDTH-1 to 0; cleared on accepted start.

Behaviour:
- Reset values: leds=0, busy=0, entry_done=0, wrapped=0, m_address=0, m_chipselect=0, state=IDLE, ptr=0, tick and hold counters=0.
- Entry format: [31:18]=hold, [17:0]=pattern. hold==0 is the end marker and its pattern is ignored.
- States:
  - IDLE: on start, ptr<=start_addr, clear wrapped, go to FETCH. start while busy is ignored.
  - FETCH (1 cycle): m_chipselect=1, m_address=ptr. Go to LATCH.
  - LATCH (1 cycle): sample m_readdata.
    - If hold!=0: leds<=pattern (visible next cycle), hold_cnt<=hold, tick_cnt<=0, go to HOLD.
    - If hold==0 and loop_en=1: ptr<=start_addr, go to FETCH.
    - If hold==0 and loop_en=0: go to IDLE; leds keep their last value.
  - HOLD: tick_cnt counts 0..PRESCALE-1. At PRESCALE-1, tick_cnt<=0 and hold_cnt decrements. When hold_cnt goes 1->0: pulse entry_done, ptr<=ptr+1 (modulo 2^ADDR_WIDTH; set wrapped on rollover), go to FETCH.
- Timing: entry period = 2 + hold*PRESCALE cycles. Start-to-first-leds-update = 3 cycles (IDLE->FETCH->LATCH->leds valid).
- stop: from any non-IDLE state, go to IDLE on the next edge. leds are retained, entry_done is not pulsed, m_chipselect deasserts.
- start and stop in the same cycle: stop wins and start is dropped.
- loop_en is sampled only in LATCH.
- A table with an end marker at start_addr and loop_en=1 re-fetches forever (2-cycle loop, no leds change). This is legal; stop exits.
- m_address holds ptr in every state, but m_chipselect is high only in FETCH.
- reset overrides everything in any state, including mid-HOLD.

Test Plan:
- PRESCALE=4. RAM[0]={2,0x00055}, RAM[1]={1,0x3FFFF}, RAM[2]=0, loop_en=0, start at addr 0 -> leds=0x00055 for 8 cycles, then 0x3FFFF for 4 cycles. entry_done pulses twice. busy falls 2 cycles after the second pulse. leds stay 0x3FFFF.
- Same table, loop_en=1 -> pattern repeats with period (2+8)+(2+4)+2 = 18 cycles; busy stays high.
- start_addr=127, RAM[127]={1,0x00001}, RAM[0]=0 -> one entry plays, then m_address=0, wrapped=1, playback ends in IDLE.
- stop pulsed mid-HOLD of RAM[0] -> busy=0 next cycle, leds=0x00055 retained, no entry_done. start and stop pulsed together from IDLE -> stays IDLE.
- reset asserted mid-HOLD -> next cycle leds=0, busy=0, m_chipselect=0, wrapped=0. start pulsed while busy -> ignored, sequence unchanged.
- Check on every cycle: m_chipselect high exactly once per entry fetch, m_write=0, m_byteenable=4'hF, m_clken=1.
